// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and payload type for the skid-buffered stage register
package pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SEL_W_DEF   = 5;
  localparam int STALL_CNT_W = 16;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [SEL_W_DEF-1:0]  sel;
    logic                  wr_en;
  } stage_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry skid buffer with registered in_ready and flush
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid, skid_valid;
  logic [W-1:0] main_data, skid_data;
  logic         accept, drain;
  logic         main_load, main_from_skid, skid_load;
  logic         main_valid_nxt, skid_valid_nxt;

  always_comb begin
    accept         = in_valid && in_ready;
    drain          = main_valid && out_ready;
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (!main_valid || drain) begin
      // in_ready is low whenever skid is full, so no accept competes with the skid move
      if (skid_valid) begin
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        main_valid_nxt = 1'b1;
        skid_valid_nxt = 1'b0;
      end else begin
        main_load      = accept;
        main_valid_nxt = accept;
      end
    end else if (accept) begin
      skid_load      = 1'b1;
      skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready   <= !skid_valid_nxt;
      if (main_load) main_data <= main_from_skid ? skid_data : in_data;
      if (skid_load) skid_data <= in_data;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - result/select/write-enable stage register with skid buffer
// Optional stall counter output enabled by PIPE_STALL_CNT_EN.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_wr_en
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int PW = DATA_W + SEL_W + 1;

  logic [PW-1:0] in_pl, out_pl;
  logic          held_wr_en;

  assign in_pl = {in_data, in_sel, in_wr_en};

  pipe_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign {out_data, out_sel, held_wr_en} = out_pl;
  // bubbles keep stale payload, so the write enable must be masked
  assign out_wr_en = held_wr_en & out_valid;

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - self-checking bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;
  import pipe_pkg::*;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] data;
    logic [4:0]  sel;
    logic        wr_en;
    logic        out_ready;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_sel = '0;
  logic        in_wr_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_sel;
  logic        out_wr_en;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] exp_stall = '0;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_wr_en  (in_wr_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_wr_en (out_wr_en)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;
  stage_payload_t sb[$];
  stage_payload_t last = '0;
  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] d,
                              logic [4:0] s, logic we, logic ordy);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.data = d;
    v.sel = s; v.wr_en = we; v.out_ready = ordy;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check();
    cmp("in_ready", 32'(in_ready), (sb.size() < 2) ? 32'd1 : 32'd0);
    cmp("out_valid", 32'(out_valid), (sb.size() > 0) ? 32'd1 : 32'd0);
    cmp("out_data", out_data, last.data);
    cmp("out_sel", 32'(out_sel), 32'(last.sel));
    cmp("out_wr_en", 32'(out_wr_en), (sb.size() > 0) ? 32'(sb[0].wr_en) : 32'd0);
`ifdef PIPE_STALL_CNT_EN
    cmp("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
  endtask

  // check the previous cycle's outcome, drive this cycle, advance the reference model
  task automatic step(input vec_t v);
    stage_payload_t p;
    bit exp_ready;
    @(negedge clk);
    if (armed) check();
    rst = v.rst; flush = v.flush; in_valid = v.in_valid;
    in_data = v.data; in_sel = v.sel; in_wr_en = v.wr_en; out_ready = v.out_ready;
    if (v.rst) begin
      sb.delete();
      last = '0;
      armed = 1'b1;
`ifdef PIPE_STALL_CNT_EN
      exp_stall = '0;
`endif
    end else begin
`ifdef PIPE_STALL_CNT_EN
      if (sb.size() > 0 && !v.out_ready && exp_stall != 16'hFFFF) exp_stall++;
`endif
      if (v.flush) begin
        sb.delete();
      end else begin
        exp_ready = (sb.size() < 2);
        if (sb.size() > 0 && v.out_ready) void'(sb.pop_front());
        if (v.in_valid && exp_ready) begin
          p.data = v.data; p.sel = v.sel; p.wr_en = v.wr_en;
          sb.push_back(p);
        end
      end
    end
    if (sb.size() > 0) last = sb[0];
  endtask

  initial begin
    // reset held two cycles with in_valid high
    vecs.push_back(mk(1, 0, 1, 32'hDEAD, 5'd7, 1, 1));
    vecs.push_back(mk(1, 0, 1, 32'hDEAD, 5'd7, 1, 1));
    // streaming
    vecs.push_back(mk(0, 0, 1, 32'h11, 5'd1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h22, 5'd2, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h33, 5'd3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));
    // backpressure
    vecs.push_back(mk(0, 0, 1, 32'hA0, 5'd4, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'hA1, 5'd5, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hA2, 5'd6, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'hA2, 5'd6, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'hA2, 5'd6, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'hA2, 5'd6, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));
    // flush with two held and a pending push
    vecs.push_back(mk(0, 0, 1, 32'hB0, 5'd8, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'hB1, 5'd9, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'hBB, 5'd10, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'hCC, 5'd11, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));
    // bubble gating
    vecs.push_back(mk(0, 0, 1, 32'hDD, 5'd12, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0, 5'd0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0, 5'd0, 1, 1));
    // reset in mid-stall
    vecs.push_back(mk(0, 0, 1, 32'hE0, 5'd13, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'hE1, 5'd14, 1, 0));
    vecs.push_back(mk(1, 0, 1, 32'hE2, 5'd15, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // explicit hold check under backpressure
    step(mk(0, 0, 1, 32'hF0, 5'd16, 1, 0));
    step(mk(0, 0, 1, 32'hF1, 5'd17, 0, 0));
    step(mk(0, 0, 1, 32'hF2, 5'd18, 1, 0));
    step(mk(0, 0, 1, 32'hF2, 5'd18, 1, 0));
    cmp("hold_data", out_data, 32'hF0);
    cmp("hold_ready", 32'(in_ready), 32'd0);
    step(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));
    step(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));
    cmp("after_drain_data", out_data, 32'hF1);
    step(mk(0, 0, 0, 32'h0, 5'd0, 0, 1));
    cmp("bubble_keep_data", out_data, 32'hF1);
    cmp("bubble_wr_en", 32'(out_wr_en), 32'd0);

`ifdef PIPE_STALL_CNT_EN
    step(mk(1, 0, 0, 32'h0, 5'd0, 0, 0));
    step(mk(0, 0, 1, 32'h55, 5'd1, 1, 0));
    for (int i = 0; i < 10; i++) step(mk(0, 0, 0, 32'h0, 5'd0, 0, 0));
    step(mk(0, 1, 0, 32'h0, 5'd0, 0, 0));
    cmp("stall_10", 32'(stall_cnt), 32'd10);
    step(mk(0, 0, 0, 32'h0, 5'd0, 0, 0));
    cmp("stall_after_flush", 32'(stall_cnt), 32'd11);
    step(mk(1, 0, 0, 32'h0, 5'd0, 0, 0));
    step(mk(0, 0, 0, 32'h0, 5'd0, 0, 0));
    cmp("stall_after_rst", 32'(stall_cnt), 32'd0);
`endif

    // random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(mk(0, ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), $urandom,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0)));
    end
    @(negedge clk);
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed 32-bit result/write-select/write-enable stage register.
- Carries a result word, a destination-register select and a write-enable between two pipeline stages.
- Adds a valid/ready handshake, a 2-entry skid buffer (registered in_ready, full throughput) and a synchronous flush.
- Drops in at any stage boundary (EX->WB, MEM->WB) where the downstream stage can stall.

Parameters:
- DATA_W, 32, width of result word.
- SEL_W, 5, width of destination register select.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; registered (= skid buffer empty).
- in_data  in  DATA_W  result word.
- in_sel  in  SEL_W  destination select.
- in_wr_en  in  1  destination write enable.
- out_valid  out  1  main entry present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  held result.
- out_sel  out  SEL_W  held select.
- out_wr_en  out  1  held write enable AND out_valid; never asserted on a bubble.

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk. All state updates on posedge clk.
- Storage: main register (drives outputs) plus skid register; each has a valid bit.
- Reset: out_valid=0, out_data=0, out_sel=0, out_wr_en=0, skid valid=0, skid contents=0, in_ready=1 on the first cycle after reset.
- Handshakes:
  - accept = in_valid && in_ready.
  - drain = out_valid && out_ready.
  - in_ready = !skid_valid, taken directly from a flop; no combinational path from out_ready.
- Per-cycle update when not flushing:
  - Main empty, or drain with skid empty: an accepted entry loads main. Latency 1 cycle from accept to out_valid.
  - Drain with skid full: skid moves to main. An accept cannot occur in this cycle because in_ready=0.
  - Main full, no drain, accept: entry loads skid. in_ready=0 next cycle.
  - Drain with no accept and skid empty: out_valid=0 next cycle.
- Throughput: 1 entry/cycle with out_ready held high. Order is strictly FIFO. Never more than 2 entries held.
- Data hold: while out_valid=1 and out_ready=0, out_data/out_sel/out_wr_en are stable.
- Bubbles: when out_valid=0, out_data/out_sel keep their last values, except 0 after reset.
- Flush:
  - Clears main and skid valid bits on the next edge; contents are not zeroed.
  - An entry accepted in the flush cycle is discarded.
  - Flush has priority over accept and drain.
  - in_ready=1 the cycle after flush.
- rst has priority over flush. Reset in mid-stall discards both entries.
- No arithmetic on payload; widths pass through unchanged.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments each cycle out_valid && !out_ready; saturates at 16'hFFFF.
  - Cleared by rst only (not flush).
- Undefined:
  - No stall_cnt port and no counter logic.
  - Port list otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - default widths: DATA_W_DEF=32, SEL_W_DEF=5.
  - STALL_CNT_W=16.
  - packed struct stage_payload_t {data, sel, wr_en} sized from package constants.
- Natural sub-module: pipe_skid_buf, a generic 2-entry payload buffer with the valid/ready logic. The top instantiates it with the concatenated payload and applies the wr_en gating and optional counter.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_sel=0, out_wr_en=0, in_ready=1 the cycle after release.
- Streaming: out_ready=1, push data 0x11,0x22,0x33 with sel 1,2,3, wr_en 1 -> same sequence on out_* with 1-cycle latency, in_ready stays 1.
- Backpressure: out_ready=0, push 0xA0 then 0xA1:
  - out_data=0xA0 held.
  - in_ready=0 after 2nd accept.
  - third push (0xA2) is not taken.
  - Raise out_ready -> 0xA0, 0xA1, 0xA2 emerge in order, no loss or duplication.
- Flush with 2 entries held and in_valid=1 (0xBB) -> next cycle out_valid=0, in_ready=1, 0xBB never appears; next push 0xCC appears after 1 cycle.
- Bubble gating: entry with wr_en=1 drained, then in_valid=0 -> out_wr_en=0 while out_valid=0.
- With PIPE_STALL_CNT_EN: hold out_ready=0 for 10 cycles with out_valid=1 -> stall_cnt=10; flush does not clear it; rst sets it to 0.
